period_meter: RTL

- Measures the slow square wave produced by the team's clock dividers (e.g. the FND scan/count clock) in i_clk cycles.
- Reports full period and high time once per input period, with a one-cycle valid strobe.
- Flags loss of signal by timeout.
- Sits beside the divider as a self-check and in bench/debug paths; the input may be asynchronous to i_clk.

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/edge_sync.sv | 29 ++
 rtl/period_meter.sv | 105 ++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and default sizing for the period meter
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 100_000_000;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer plus delay flop with rise/fall pulses
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow input in clock cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic             rise;
    logic             fall;
    logic             at_limit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             valid;
    logic             locked;
    logic             timeout;

    edge_sync u_edge_sync (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .din     (i_sig),
        .rise    (rise),
        .fall    (fall)
    );

    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rise in the limit cycle still completes the measurement
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = MEASURE;
            MEASURE: if (!rise && at_limit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            hi_tmp  <= '0;
            period  <= '0;
            high    <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (rise) begin
                    locked <= 1'b1;
                end
            end else if (rise) begin
                period  <= cnt + ONE;
                high    <= hi_tmp;
                valid   <= 1'b1;
                cnt     <= '0;
                timeout <= 1'b0;
            end else if (at_limit) begin
                locked  <= 1'b0;
                timeout <= 1'b1;
                period  <= '0;
                high    <= '0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + ONE;
                if (fall) begin
                    hi_tmp <= cnt + ONE;
                end
            end
        end
    end

    assign o_period  = period;
    assign o_high    = high;
    assign o_valid   = valid;
    assign o_locked  = locked;
    assign o_timeout = timeout;

endmodule
